alt_cmd_gen: RTL and testbench
==============================

# alt_cmd_gen

Closed-loop altitude command generator producing the 3-bit `altcmd` code consumed by the drone's altitude RPM controller.
- Accepts a target altitude over a valid/ready handshake and sensed altitude samples from the altimeter front end.
- Quantizes the signed error into a climb/descend magnitude and rate-limits magnitude changes with a dwell timer.
- Drives a safe descent code on sensor timeout.
- Sits between flight-plan logic and the RPM controller in the drone controller datapath.

## Interface
- `ALT_W`, 16, altitude width (unsigned, arbitrary units).
- `DEADBAND`, 16'd8, error magnitude at or below which the command is neutral.
- `BAND1`, 16'd64, error magnitude at or below which magnitude is 1.
- `BAND2`, 16'd256, error magnitude at or below which magnitude is 2; above it, magnitude is 3.
- `DWELL`, 8'd50, minimum cycles between successive `altcmd` changes; must be ≥1.
- `TIMEOUT`, 16'd1000, cycles without `sns_valid` while enabled before fault.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `enable`  in  1  loop enable; low forces IDLE.
- `tgt_alt`  in  ALT_W  target altitude.
- `tgt_valid`  in  1  target offer.
- `tgt_ready`  out  1  target accept.
- `sns_alt`  in  ALT_W  sensed altitude.
- `sns_valid`  in  1  one-cycle sample strobe.
- `altcmd`  out  3  bit2 = descend (0 = climb), bits[1:0] = magnitude 0..3; neutral is always emitted as 3'b000.
- `fault`  out  1  sensor timeout latched.
- `hold`  out  1  high in HOLD state.

## Operation
- **Target handshake:** `tgt_ready` = 1 in IDLE, TRACK and HOLD, and 0 in FAULT.
  - Target is captured when `tgt_valid && tgt_ready`, which also sets `have_tgt`.
  - A new target is accepted at any time and replaces the old one; the current magnitude ramps from its present value.
- **Sample and error:** on `sns_valid`, register `err = tgt - sns` as a signed ALT_W+1 value.
  - Take `|err|` as ALT_W+1 bits; no saturation is needed.
  - Comparisons are unsigned against the zero-extended parameters.
- **Desired magnitude `dmag`:**
  - 0 if `|err| ≤ DEADBAND`.
  - 1 if `|err| ≤ BAND1`.
  - 2 if `|err| ≤ BAND2`.
  - 3 otherwise.
- **Desired direction `ddir`:** `err < 0`.
- **Rate limit:** `altcmd` changes only when `dwell_cnt == 0`. Each change moves the current magnitude `cmag` by exactly ±1 toward `dmag`.
  - If `ddir` differs from the current direction and `cmag > 0`, step `cmag` down first.
  - The direction bit flips only when `cmag` goes 0→1.
  - Every change reloads `dwell_cnt` with DWELL-1; it decrements to 0 and holds there.
- **States:**
  - **IDLE:** `altcmd = 000`. Go to TRACK when `enable && have_tgt` and the first `sns_valid` arrives.
  - **TRACK:** ramps as above. Go to HOLD when `cmag == 0` and `dmag == 0`.
  - **HOLD:** `altcmd = 000`, `hold = 1`. Go to TRACK when a sample gives `|err| > 2*DEADBAND` (hysteresis). `dmag` in the band (DEADBAND, 2*DEADBAND] stays in HOLD.
  - **FAULT:** `altcmd = 3'b101`, `fault = 1`. Entered from TRACK or HOLD when `timeout_cnt` reaches TIMEOUT. Exit to IDLE only when `enable = 0`.
  - **Any state:** `enable = 0` gives IDLE on the next edge, with `altcmd = 000`, `cmag = 0`, and `dwell_cnt` and `timeout_cnt` cleared. `have_tgt` is retained.
- **Timeout counter:** counts in TRACK and HOLD, clears on `sns_valid`, and saturates at TIMEOUT.
- **Simultaneous events:** `sns_valid` in the same cycle as a target capture uses the new target (`tgt_alt` is bypassed into the subtract). `enable = 0` overrides everything.

## Timing
- **Reset values:**
  - `altcmd` = 000, `tgt_ready` = 1, `fault` = 0, `hold` = 0.
  - State IDLE, `have_tgt` = 0.
  - All counters 0.
- Reset mid-ramp takes effect on the next edge, with no neutral ramp-down.
- **Latency:** `sns_valid` in cycle k gives `err` registered at edge k. `altcmd` updates at edge k+1 if `dwell_cnt == 0` in cycle k+1, for 2 cycles total.
- **Magnitude steps:** minimum spacing between `altcmd` changes is DWELL cycles.
  - A full reversal 3 climb → 3 descend takes 6 changes, so 5·DWELL+2 cycles minimum from the sample.
- **Fault timing:** `fault` asserts at the edge where `timeout_cnt` reaches TIMEOUT, i.e. TIMEOUT cycles after the last sample.

## Structure
- **Package `alt_pkg`:**
  - `alt_state_t` enum {IDLE, TRACK, HOLD, FAULT}.
  - Constants `CMD_NEUTRAL` = 3'b000 and `CMD_FAULT` = 3'b101.
  - Function `enc_altcmd(dir, mag)` returning 000 when `mag == 0`.
  - These are shared with the RPM controller and its bench.
- **Sub-module `alt_err_quant`:** combinational; `|err|`, DEADBAND/BAND1/BAND2 and the hysteresis threshold → `dmag`, `ddir` and `exceeds_hyst`.
- The FSM, dwell timer, timeout timer and handshake stay in `alt_cmd_gen`.

## Test plan
Bench parameters: DWELL=4, TIMEOUT=20.
- **Climb ramp:** target 1000, samples of 600 every cycle → `altcmd` 001, 010, 011 at 4-cycle spacing, then held at 011.
- **Band settle:** samples 900, then 950, then 995 → magnitude steps down to 2, then 1, then 0; state HOLD, `hold = 1`, `altcmd = 000`.
- **Hysteresis:** in HOLD with target 1000, sample 985 (err 15) → stays HOLD; sample 983 (err 17) → TRACK, `altcmd = 001` two cycles later.
- **Reversal:** at 011 climb, new target 200 with sample 1000 → 010, 001, 000, 101, 110, 111, each ≥4 cycles apart, with no direct 011→1xx.
- **Timeout:** in TRACK, stop `sns_valid` for 20 cycles → `fault = 1`, `altcmd = 101`, `tgt_ready = 0`; deassert `enable` → IDLE, `altcmd = 000`, `fault = 0`.
- **Reset and collision:** `resetn = 0` mid-ramp → all outputs at reset values on the next edge. Target capture and `sns_valid` in the same cycle → error computed from the new target.

Source files
------------

// File: rtl/alt_cmd_gen_pkg.sv
// alt_cmd_gen shared types and command encoding.
// Also used by the RPM controller and its bench.
package alt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD,
    FAULT
  } alt_state_t;

  localparam logic [2:0] CMD_NEUTRAL = 3'b000;
  localparam logic [2:0] CMD_FAULT   = 3'b101;

  // Neutral is always emitted as 000, whatever
  // the direction bit holds.
  function automatic logic [2:0] enc_altcmd(
    input logic       dir,
    input logic [1:0] mag
  );
    logic [2:0] r;
    if (mag == 2'd0)
      r = CMD_NEUTRAL;
    else
      r = {dir, mag};
    return r;
  endfunction

endpackage

// File: rtl/alt_cmd_gen_if.sv
// alt_cmd_gen target and altimeter sample bus.
// master = flight plan / altimeter side.
interface alt_cmd_gen_if #(
  parameter int unsigned ALT_W = 16
);

  logic [ALT_W-1:0] tgt_alt;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [ALT_W-1:0] sns_alt;
  logic             sns_valid;

  modport master (
    output tgt_alt,
    output tgt_valid,
    input  tgt_ready,
    output sns_alt,
    output sns_valid
  );

  modport slave (
    input  tgt_alt,
    input  tgt_valid,
    output tgt_ready,
    input  sns_alt,
    input  sns_valid
  );

endinterface

// File: rtl/alt_cmd_gen_err_quant.sv
// alt_cmd_gen error quantizer.
// Signed error -> desired magnitude/direction.
module alt_err_quant
  import alt_pkg::*;
#(
  parameter int unsigned ALT_W = 16
) (
  input  logic signed [ALT_W:0] i_err,
  input  logic [ALT_W-1:0]      i_deadband,
  input  logic [ALT_W-1:0]      i_band1,
  input  logic [ALT_W-1:0]      i_band2,
  input  logic [ALT_W:0]        i_hyst,
  output logic [1:0]            o_dmag,
  output logic                  o_ddir,
  output logic                  o_exceeds_hyst
);

  logic [ALT_W:0] w_abs;
  logic [ALT_W:0] w_db;
  logic [ALT_W:0] w_b1;
  logic [ALT_W:0] w_b2;

  // tgt - sns never reaches the most negative
  // value, so the negation cannot overflow.
  assign w_abs = i_err[ALT_W]
               ? $unsigned(-i_err)
               : $unsigned(i_err);

  assign w_db = {1'b0, i_deadband};
  assign w_b1 = {1'b0, i_band1};
  assign w_b2 = {1'b0, i_band2};

  // Band lookup, innermost band first.
  always_comb begin
    o_dmag = 2'd3;
    if (w_abs <= w_db)
      o_dmag = 2'd0;
    else if (w_abs <= w_b1)
      o_dmag = 2'd1;
    else if (w_abs <= w_b2)
      o_dmag = 2'd2;
  end

  assign o_ddir         = i_err[ALT_W];
  assign o_exceeds_hyst = (w_abs > i_hyst);

endmodule

// File: rtl/alt_cmd_gen.sv
// alt_cmd_gen: closed-loop altitude command FSM.
// Rate-limited ramp of altcmd toward the error band.
module alt_cmd_gen
  import alt_pkg::*;
#(
  parameter int unsigned      ALT_W    = 16,
  parameter logic [ALT_W-1:0] DEADBAND = 16'd8,
  parameter logic [ALT_W-1:0] BAND1    = 16'd64,
  parameter logic [ALT_W-1:0] BAND2    = 16'd256,
  parameter logic [7:0]       DWELL    = 8'd50,
  parameter logic [15:0]      TIMEOUT  = 16'd1000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_enable,
  alt_cmd_gen_if.slave bus,
  output logic [2:0]   o_altcmd,
  output logic         o_fault,
  output logic         o_hold
);

  alt_state_t r_state;
  alt_state_t w_state_nxt;

  logic [ALT_W-1:0]    r_tgt;
  logic                r_have_tgt;
  logic signed [ALT_W:0] r_err;
  logic [1:0]          r_cmag;
  logic                r_dir;
  logic [7:0]          r_dwell;
  logic [15:0]         r_tmo;

  logic [1:0]          w_cmag_nxt;
  logic                w_dir_nxt;
  logic [7:0]          w_dwell_nxt;
  logic [15:0]         w_tmo_nxt;

  logic                w_rdy;
  logic                w_cap;
  logic                w_have;
  logic [ALT_W-1:0]    w_tgt_eff;
  logic signed [ALT_W:0] w_err_new;
  logic [ALT_W:0]      w_hyst;

  logic [1:0]          w_dmag;
  logic                w_ddir;
  logic                w_exceeds;

  logic [1:0]          w_step_mag;
  logic                w_step_dir;
  logic                w_step_chg;
  logic                w_take;
  logic                w_dwell_ok;
  logic [15:0]         w_tmo_inc;
  logic                w_tmo_hit;

  assign w_rdy         = (r_state != FAULT);
  assign bus.tgt_ready = w_rdy;
  assign w_cap         = bus.tgt_valid & w_rdy;
  assign w_have        = r_have_tgt | w_cap;

  // A target captured this cycle feeds the
  // subtract directly.
  assign w_tgt_eff = w_cap ? bus.tgt_alt : r_tgt;
  assign w_err_new = $signed({1'b0, w_tgt_eff})
                   - $signed({1'b0, bus.sns_alt});

  assign w_hyst = {DEADBAND, 1'b0};

  alt_err_quant #(
    .ALT_W (ALT_W)
  ) u_quant (
    .i_err          (r_err),
    .i_deadband     (DEADBAND),
    .i_band1        (BAND1),
    .i_band2        (BAND2),
    .i_hyst         (w_hyst),
    .o_dmag         (w_dmag),
    .o_ddir         (w_ddir),
    .o_exceeds_hyst (w_exceeds)
  );

  assign w_dwell_ok = (r_dwell == 8'd0);

  assign w_tmo_inc = bus.sns_valid      ? 16'd0
                   : (r_tmo == TIMEOUT) ? r_tmo
                   : r_tmo + 16'd1;
  assign w_tmo_hit = (w_tmo_inc == TIMEOUT);

  // One +-1 magnitude step toward the goal;
  // reversals pass through zero first.
  always_comb begin
    w_step_mag = r_cmag;
    w_step_dir = r_dir;
    w_step_chg = 1'b0;
    if (r_cmag != 2'd0 && w_ddir != r_dir) begin
      w_step_mag = r_cmag - 2'd1;
      w_step_chg = 1'b1;
    end else if (r_cmag == 2'd0 &&
                 w_dmag != 2'd0) begin
      w_step_mag = 2'd1;
      w_step_dir = w_ddir;
      w_step_chg = 1'b1;
    end else if (r_cmag < w_dmag) begin
      w_step_mag = r_cmag + 2'd1;
      w_step_chg = 1'b1;
    end else if (r_cmag > w_dmag) begin
      w_step_mag = r_cmag - 2'd1;
      w_step_chg = 1'b1;
    end
  end

  // Next state, ramp and timer updates;
  // a low enable overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cmag_nxt  = r_cmag;
    w_dir_nxt   = r_dir;
    w_dwell_nxt = w_dwell_ok ? 8'd0
                : r_dwell - 8'd1;
    w_tmo_nxt   = r_tmo;
    w_take      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_tmo_nxt = 16'd0;
        if (i_enable && w_have &&
            bus.sns_valid)
          w_state_nxt = TRACK;
      end
      TRACK: begin
        w_tmo_nxt = w_tmo_inc;
        if (w_tmo_hit)
          w_state_nxt = FAULT;
        else if (r_cmag == 2'd0 &&
                 w_dmag == 2'd0)
          w_state_nxt = HOLD;
        else
          w_take = w_dwell_ok & w_step_chg;
      end
      HOLD: begin
        w_tmo_nxt = w_tmo_inc;
        if (w_tmo_hit) begin
          w_state_nxt = FAULT;
        end else if (w_exceeds) begin
          w_state_nxt = TRACK;
          w_take = w_dwell_ok & w_step_chg;
        end
      end
      FAULT: begin
      end
    endcase

    if (w_take) begin
      w_cmag_nxt  = w_step_mag;
      w_dir_nxt   = w_step_dir;
      w_dwell_nxt = DWELL - 8'd1;
    end

    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_cmag_nxt  = 2'd0;
      w_dir_nxt   = 1'b0;
      w_dwell_nxt = 8'd0;
      w_tmo_nxt   = 16'd0;
    end
  end

  // State, ramp, target and error registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_tgt      <= '0;
      r_have_tgt <= 1'b0;
      r_err      <= '0;
      r_cmag     <= 2'd0;
      r_dir      <= 1'b0;
      r_dwell    <= 8'd0;
      r_tmo      <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cmag  <= w_cmag_nxt;
      r_dir   <= w_dir_nxt;
      r_dwell <= w_dwell_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_cap) begin
        r_tgt      <= bus.tgt_alt;
        r_have_tgt <= 1'b1;
      end
      if (bus.sns_valid)
        r_err <= w_err_new;
    end
  end

  // Output decode from registered state.
  always_comb begin
    o_altcmd = CMD_NEUTRAL;
    unique case (1'b1)
      (r_state == TRACK):
        o_altcmd = enc_altcmd(r_dir, r_cmag);
      (r_state == FAULT):
        o_altcmd = CMD_FAULT;
      default:
        o_altcmd = CMD_NEUTRAL;
    endcase
  end

  assign o_fault = (r_state == FAULT);
  assign o_hold  = (r_state == HOLD);

endmodule

// File: tb/tb_alt_cmd_gen.sv
// alt_cmd_gen bench: directed vectors with an
// altcmd change scoreboard, DWELL=4, TIMEOUT=20.
module tb_alt_cmd_gen;
  import alt_pkg::*;

  localparam int DW = 4;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [2:0] altcmd;
  logic       fault;
  logic       hold;

  alt_cmd_gen_if #(.ALT_W(16)) bus ();

  alt_cmd_gen #(
    .DWELL   (8'd4),
    .TIMEOUT (16'd20)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_enable (enable),
    .bus      (bus),
    .o_altcmd (altcmd),
    .o_fault  (fault),
    .o_hold   (hold)
  );

  typedef struct packed {
    logic [2:0] cmd;
    logic       gap;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [2:0] last_cmd = 3'b000;
  bit         mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] c,
                      input logic g);
    exp_t e;
    e.cmd = c;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every altcmd change must match the
  // next expected code and respect dwell spacing.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && altcmd !== last_cmd) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected act=%b exp=none",
                 altcmd);
      end else begin
        e = q.pop_front();
        if (altcmd !== e.cmd) begin
          errors++;
          $display("FAIL cmd_seq act=%b exp=%b",
                   altcmd, e.cmd);
        end
        if (e.gap) begin
          checks++;
          if (cyc - last_cyc < DW) begin
            errors++;
            $display("FAIL cmd_gap act=%0d exp>=%0d",
                     cyc - last_cyc, DW);
          end
        end
      end
      last_cmd = altcmd;
      last_cyc = cyc;
    end
  end

  initial begin
    resetn        = 1'b0;
    enable        = 1'b0;
    bus.tgt_alt   = '0;
    bus.tgt_valid = 1'b0;
    bus.sns_alt   = '0;
    bus.sns_valid = 1'b0;
    step(3);
    chk("rst_cmd", altcmd, 0);
    chk("rst_ready", bus.tgt_ready, 1);
    chk("rst_fault", fault, 0);
    chk("rst_hold", hold, 0);
    resetn = 1'b1;
    last_cmd = altcmd;
    mon_en = 1;
    enable = 1'b1;

    // climb ramp
    bus.tgt_alt   = 16'd1000;
    bus.tgt_valid = 1'b1;
    step(1);
    bus.tgt_valid = 1'b0;
    push(3'b001, 1'b0);
    push(3'b010, 1'b1);
    push(3'b011, 1'b1);
    bus.sns_alt   = 16'd600;
    bus.sns_valid = 1'b1;
    step(1);
    chk("climb_lat0", altcmd, 3'b000);
    step(1);
    chk("climb_lat1", altcmd, 3'b001);
    step(12);
    chk("climb_top", altcmd, 3'b011);

    // band settle into HOLD
    push(3'b010, 1'b1);
    bus.sns_alt = 16'd900;
    step(8);
    push(3'b001, 1'b1);
    bus.sns_alt = 16'd950;
    step(8);
    push(3'b000, 1'b1);
    bus.sns_alt = 16'd995;
    step(8);
    chk("settle_hold", hold, 1);
    chk("settle_cmd", altcmd, 3'b000);

    // hysteresis band
    bus.sns_alt = 16'd985;
    step(6);
    chk("hyst_in_hold", hold, 1);
    chk("hyst_in_cmd", altcmd, 3'b000);
    push(3'b001, 1'b1);
    bus.sns_alt = 16'd983;
    step(1);
    chk("hyst_lat0", altcmd, 3'b000);
    step(1);
    chk("hyst_lat1", altcmd, 3'b001);
    chk("hyst_track", hold, 0);

    // back to full climb
    push(3'b010, 1'b1);
    push(3'b011, 1'b1);
    bus.sns_alt = 16'd600;
    step(14);
    chk("reclimb", altcmd, 3'b011);

    // reversal with colliding target/sample
    push(3'b010, 1'b1);
    push(3'b001, 1'b1);
    push(3'b000, 1'b1);
    push(3'b101, 1'b1);
    push(3'b110, 1'b1);
    push(3'b111, 1'b1);
    bus.tgt_alt   = 16'd200;
    bus.tgt_valid = 1'b1;
    bus.sns_alt   = 16'd1000;
    step(1);
    bus.tgt_valid = 1'b0;
    chk("rev_lat0", altcmd, 3'b011);
    step(1);
    chk("rev_lat1", altcmd, 3'b010);
    step(24);
    chk("rev_end", altcmd, 3'b111);

    // sensor timeout
    bus.sns_valid = 1'b0;
    push(3'b101, 1'b0);
    step(19);
    chk("tmo_pre_fault", fault, 0);
    chk("tmo_pre_cmd", altcmd, 3'b111);
    step(1);
    chk("tmo_fault", fault, 1);
    chk("tmo_cmd", altcmd, 3'b101);
    chk("tmo_ready", bus.tgt_ready, 0);
    chk("tmo_hold", hold, 0);

    // disable clears fault
    push(3'b000, 1'b0);
    enable = 1'b0;
    step(1);
    chk("dis_cmd", altcmd, 3'b000);
    chk("dis_fault", fault, 0);
    chk("dis_ready", bus.tgt_ready, 1);

    // reset mid-ramp
    enable        = 1'b1;
    bus.tgt_alt   = 16'd1000;
    bus.tgt_valid = 1'b1;
    step(1);
    bus.tgt_valid = 1'b0;
    push(3'b001, 1'b0);
    push(3'b010, 1'b1);
    bus.sns_alt   = 16'd600;
    bus.sns_valid = 1'b1;
    step(7);
    chk("ramp2_mid", altcmd, 3'b010);
    push(3'b000, 1'b0);
    resetn = 1'b0;
    step(1);
    chk("mrst_cmd", altcmd, 3'b000);
    chk("mrst_ready", bus.tgt_ready, 1);
    chk("mrst_fault", fault, 0);
    chk("mrst_hold", hold, 0);
    step(1);
    resetn = 1'b1;
    step(5);
    chk("no_tgt_idle", altcmd, 3'b000);

    // capture and sample in the same cycle
    push(3'b001, 1'b0);
    bus.tgt_alt   = 16'd1000;
    bus.tgt_valid = 1'b1;
    bus.sns_alt   = 16'd990;
    step(1);
    bus.tgt_valid = 1'b0;
    bus.sns_valid = 1'b0;
    chk("coll_lat0", altcmd, 3'b000);
    step(1);
    chk("coll_cmd", altcmd, 3'b001);

    push(3'b000, 1'b0);
    enable = 1'b0;
    step(2);
    chk("end_cmd", altcmd, 3'b000);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
